// File: rtl/enc_div_scheduler.sv
// enc_div_scheduler: round-robin scheduler in front of one shared iterative
// restoring divider for the per-wheel encoder speed paths.
//
// quotient = floor(numer * 2^FRAC_BITS / denom), saturated to WIDTH bits.
// Optional feature (macro ENC_DIV_ROUND_EN): when defined, denom/2 is added to
// the dividend so the quotient rounds to nearest; latency is unchanged.
//
// Ports:
//   sclk       system clock
//   rstn       asynchronous active-low reset (deasserted synchronously inside)
//   req        per-channel level request, held until that channel's done
//   numer      packed numerators, channel k at [k*WIDTH +: WIDTH]
//   denom      packed denominators, same packing
//   grant      one-hot pulse in the cycle a channel's operands are captured
//   done       one-hot pulse when that channel's result is valid
//   result     last completed quotient, held until the next done
//   result_ch  channel index of result
//   div_zero   last completed division had denom == 0
//   ovf        last completed division saturated
//   busy       high while the divider is in DIV or DONE
module enc_div_scheduler #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 5
) (
  input  logic                      sclk,
  input  logic                      rstn,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*WIDTH-1:0]   numer,
  input  logic [NUM_CH*WIDTH-1:0]   denom,
  output logic [NUM_CH-1:0]         grant,
  output logic [NUM_CH-1:0]         done,
  output logic [WIDTH-1:0]          result,
  output logic [$clog2(NUM_CH)-1:0] result_ch,
  output logic                      div_zero,
  output logic                      ovf,
  output logic                      busy
);

  localparam int unsigned CHW = $clog2(NUM_CH);
  localparam int unsigned QW  = WIDTH + FRAC_BITS;  // quotient / dividend bits
  localparam int unsigned CW  = $clog2(QW);         // iteration counter bits

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state;
  logic [CHW-1:0]   ptr;
  logic [CHW-1:0]   cur_ch;
  logic [WIDTH-1:0] den;
  logic [QW-1:0]    rem;
  logic [QW-1:0]    dvd;     // dividend shifts out the top, quotient bits shift in
  logic [CW-1:0]    cnt;

  // Reset synchronizer: assertion is immediate, release is aligned to sclk.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_i = rst_sync[1];

  // Round-robin pick: first requesting channel at or after ptr (mod NUM_CH).
  // Scanning from the farthest offset down leaves the nearest hit in pick_ch.
  logic           pick_v;
  logic [CHW-1:0] pick_ch;
  int             idx;

  always_comb begin
    pick_v  = 1'b0;
    pick_ch = '0;
    idx     = 0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(NUM_CH)) begin
        idx = idx - int'(NUM_CH);
      end
      if (req[CHW'(idx)]) begin
        pick_v  = 1'b1;
        pick_ch = CHW'(idx);
      end
    end
  end

  // Operands of the picked channel and the initial dividend.
  logic [WIDTH-1:0] sel_numer;
  logic [WIDTH-1:0] sel_denom;
  logic [QW:0]      dvd_init;

  always_comb begin
    sel_numer = numer[pick_ch*WIDTH +: WIDTH];
    sel_denom = denom[pick_ch*WIDTH +: WIDTH];
`ifdef ENC_DIV_ROUND_EN
    dvd_init  = ((QW+1)'(sel_numer) << FRAC_BITS) + (QW+1)'(sel_denom >> 1);
`else
    dvd_init  = (QW+1)'(sel_numer) << FRAC_BITS;
`endif
  end

  // One restoring step. The rounding carry (dvd_init[QW]) is preloaded into
  // rem; it can only be 1 when den >= 2, so rem < den holds from the start
  // and the quotient always fits in QW bits.
  logic [QW:0]   trial;
  logic          trial_ge;
  logic [QW-1:0] rem_next;

  always_comb begin
    trial    = {rem, dvd[QW-1]};
    trial_ge = (trial >= (QW+1)'(den));
    rem_next = trial_ge ? QW'(trial - (QW+1)'(den)) : QW'(trial);
  end

  // Any quotient bit above the WIDTH low bits means saturation.
  logic q_hi_nz;
  assign q_hi_nz = ((dvd >> WIDTH) != '0);

  // Scheduler / divider FSM with registered outputs.
  always_ff @(posedge sclk or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cur_ch    <= '0;
      den       <= '0;
      rem       <= '0;
      dvd       <= '0;
      cnt       <= '0;
      grant     <= '0;
      done      <= '0;
      result    <= '0;
      result_ch <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_v) begin
            grant  <= NUM_CH'(1) << pick_ch;
            cur_ch <= pick_ch;
            ptr    <= (pick_ch == CHW'(NUM_CH - 1)) ? '0 : pick_ch + CHW'(1);
            den    <= sel_denom;
            dvd    <= dvd_init[QW-1:0];
            rem    <= QW'(dvd_init[QW]);
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= (sel_denom == '0) ? S_DONE : S_DIV;
          end
        end

        S_DIV: begin
          rem <= rem_next;
          dvd <= {dvd[QW-2:0], trial_ge};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(QW - 1)) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done      <= NUM_CH'(1) << cur_ch;
          result_ch <= cur_ch;
          busy      <= 1'b0;
          state     <= S_IDLE;
          if (den == '0) begin
            result   <= '1;
            div_zero <= 1'b1;
            ovf      <= 1'b0;
          end else if (q_hi_nz) begin
            result   <= '1;
            div_zero <= 1'b0;
            ovf      <= 1'b1;
          end else begin
            result   <= dvd[WIDTH-1:0];
            div_zero <= 1'b0;
            ovf      <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/enc_div_scheduler.md
Name: enc_div_scheduler

Overview:
Shared fixed-point divider with a round-robin scheduler for the per-wheel encoder speed paths. Each encoder channel presents a numerator/denominator pair, for example pulse counts over a sample window or clock ticks per count. The block grants one channel at a time and runs a single iterative restoring divider. It returns a quotient with FRAC_BITS fractional bits, saturated to WIDTH bits, so the rover needs one divider instead of one combinational divider per channel.

Parameters:
NUM_CH, 4, number of requesting encoder channels (2..8)
WIDTH, 32, numerator/denominator/result width in bits
FRAC_BITS, 5, fractional bits in the result; quotient = floor(numer * 2^FRAC_BITS / denom)

Ports:
sclk  input  1  system clock
rstn  input  1  asynchronous active-low reset
req  input  NUM_CH  per-channel request, level; held until that channel's done
numer  input  NUM_CH*WIDTH  packed numerators, channel k at [k*WIDTH +: WIDTH]
denom  input  NUM_CH*WIDTH  packed denominators, same packing
grant  output  NUM_CH  one-hot, one-cycle pulse when a channel's operands are captured
done  output  NUM_CH  one-hot, one-cycle pulse when that channel's result is valid
result  output  WIDTH  quotient of the last completed division, held until the next done
result_ch  output  $clog2(NUM_CH)  channel index of result
div_zero  output  1  last completed division had denom == 0
ovf  output  1  last completed division saturated
busy  output  1  high in DIV and DONE

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE; grant, done, result, result_ch, div_zero, ovf and busy all 0; round-robin pointer at ch0. An assertion mid-division aborts it; no done is issued.
- States:
  - IDLE: if any req, pick the first requesting channel at or after the pointer (mod NUM_CH). Pulse its grant bit and capture numer/denom into internal registers. Set the pointer to the granted channel + 1 (mod NUM_CH). Go to DIV, or go directly to DONE if the captured denom == 0.
  - DIV: restoring division, one quotient bit per cycle over a (WIDTH+FRAC_BITS)-bit dividend (numer << FRAC_BITS). Runs exactly WIDTH+FRAC_BITS cycles, then goes to DONE.
  - DONE: pulse done[ch]; update result, result_ch, div_zero and ovf; go to IDLE.
- Latency: the grant cycle is cycle 0. done occurs at cycle WIDTH+FRAC_BITS+1, which is 38 for the defaults, or at cycle 1 when denom == 0. At least one IDLE cycle separates consecutive grants.
- Saturation: if any of the upper FRAC_BITS bits of the internal quotient are nonzero, result = all ones and ovf = 1; otherwise result = the low WIDTH bits and ovf = 0.
- Divide by zero: result = all ones, div_zero = 1, ovf = 0.
- Operands are sampled only in the grant cycle; later changes on numer/denom do not affect the division in flight.
- A req dropped mid-division: the division completes and done still pulses.
- A req still high in the IDLE cycle after its done is treated as a new request, at round-robin priority.
- Simultaneous requests resolve strictly by the pointer; no channel waits more than NUM_CH-1 services.
- Denominators are unsigned. The datapath is WIDTH+FRAC_BITS+1 bits for the partial remainder.

Optional Feature:
ENC_DIV_ROUND_EN
- Defined: the dividend is (numer << FRAC_BITS) + (denom >> 1), giving round-to-nearest. Saturation is checked after rounding. Latency is unchanged.
- Undefined: the quotient is truncated (floor).

Test Plan:
- req[0]=1, numer0=100, denom0=8 -> grant[0] at cycle 0; done[0] at cycle 38; result=400 (0x190); div_zero=0; ovf=0.
- req=4'b1111 held, all denom=1, numer k = k+1 -> grants issued in order ch0,ch1,ch2,ch3,ch0; each result = (k+1)*32; result_ch matches the granted channel.
- req[2]=1, denom2=0, numer2=5 -> done[2] 1 cycle after grant; result=0xFFFFFFFF; div_zero=1; ovf=0.
- req[1]=1, numer1=0xFFFFFFFF, denom1=1 -> result=0xFFFFFFFF; ovf=1; div_zero=0.
- req[3]=1, numer3=1, denom3=3 -> result=10 with ENC_DIV_ROUND_EN undefined, 11 with it defined.
- rstn pulsed low at cycle 20 of a division -> all outputs 0 immediately; no done for the aborted channel; after release, a pending req[0] is granted first.
